free_list_mw: RTL
=================

Name: free_list_mw

Overview:
- Multi-width physical-register free list for the mp_ooo rename stage.
- Parametrised successor to the fixed 32-deep, 1-alloc/1-free free list sized by FREE_LIST_DEPTH/FREE_LIST_WIDTH.
- Supports ALLOC_W allocations and FREE_W releases per cycle.
- Keeps a speculative head and a committed head so a ROB flush restores the list in one cycle.

Parameters:
- PR_W, 6, physical register index width (matches PR_WIDTH).
- DEPTH, 32, number of free-list entries; power of two.
- ALLOC_W, 2, max allocations per cycle (rename width).
- FREE_W, 2, max releases per cycle (commit width).
- NUM_ARCH, 32, first PR loaded at reset; reset contents are NUM_ARCH..NUM_ARCH+DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_cnt  in  $clog2(ALLOC_W+1)  allocations requested this cycle; honoured only when alloc_ready=1.
- alloc_ready  out  1  spec_count >= ALLOC_W.
- alloc_pr  out  ALLOC_W*PR_W  lane i = mem[spec_head+i]; combinational, valid when alloc_ready.
- free_valid  in  FREE_W  per-lane release valid; any bit pattern is legal.
- free_pr  in  FREE_W*PR_W  per-lane released PR (old pd of the committing instruction).
- commit_cnt  in  $clog2(ALLOC_W+1)  allocations retired this cycle; advances commit_head.
- flush  in  1  mispredict recovery: spec_head <= commit_head.
- spec_count  out  $clog2(DEPTH)+1  entries currently free (speculative view).
- empty  out  1  spec_count==0.
- ovf_err  out  1  sticky; set when a release would exceed DEPTH.
- dup_err  out  1  sticky duplicate-release flag (optional feature only).

Behaviour:
- Storage:
  - mem[DEPTH] of PR_W bits.
  - Pointers spec_head, commit_head and tail are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - spec_count = tail - spec_head, modulo 2^(ptr width).
- Reset (async, rst=0):
  - mem[i]=NUM_ARCH+i.
  - spec_head=commit_head=0; tail=DEPTH (wrap bit set).
  - spec_count=DEPTH, empty=0, alloc_ready=1, ovf_err=0, dup_err=0.
  - alloc_pr = {NUM_ARCH+1, NUM_ARCH} on lanes 1,0.
- Allocate:
  - Condition: alloc_ready && !flush && alloc_cnt>0.
  - Next edge: spec_head += alloc_cnt.
  - Lanes 0..alloc_cnt-1 consumed in order.
  - alloc_cnt is ignored when alloc_ready=0; all-or-nothing, no partial grant.
- Release:
  - Valid lanes are compacted in ascending lane order.
  - Written to mem[tail], mem[tail+1], ...; tail += popcount(free_valid).
  - Applied regardless of flush.
- Commit: commit_head += commit_cnt every cycle.
  - Illegal for commit_cnt to pass spec_head; checked by simulation assertion.
- Flush: spec_head <= commit_head + commit_cnt (same-cycle commit included). The alloc is dropped.
- Simultaneous alloc+release: spec_count_next = spec_count - alloc + popcount(free_valid).
  - A PR freed this cycle is not allocatable until the next cycle; no bypass.
- Wrap: indices use the low $clog2(DEPTH) bits. The pointer MSB toggles on wrap, so full is distinguishable from empty.
- Overflow:
  - Triggered when spec_count + popcount(free_valid) - alloc > DEPTH.
  - The release is dropped (tail unchanged) and ovf_err is set.
  - ovf_err clears only on reset.
- Latency: alloc_pr is combinational from state. All updates are visible the cycle after the edge.

Optional Feature:
- FREE_LIST_DUP_CHECK_EN defined:
  - Maintains an in_list bit vector over 2^PR_W PRs; reset sets bits NUM_ARCH..NUM_ARCH+DEPTH-1.
  - Allocation clears a bit; release sets it.
  - Flush re-sets the bits of entries between commit_head and the old spec_head.
  - A release of a PR whose bit is already set is dropped for that lane only and sets dup_err (sticky).
- Not defined: no vector; dup_err tied to 0.

Decomposition:
- Add FL_DEPTH, ALLOC_WIDTH and FREE_WIDTH localparams to rv32i_types.
- Ptr width is derived in-module.
- Sub-module free_list_compact: combinational prefix-popcount.
  - Maps free_valid/free_pr to packed write lanes plus a count.
  - Reused by the ROB commit path.

Test Plan:
- Reset release -> spec_count=32, alloc_ready=1, alloc_pr lanes {33,32}, ovf_err=0.
- Empty boundary: alloc_cnt=2 for 16 cycles -> spec_count=0, empty=1, alloc_ready=0. A 17th alloc_cnt=2 leaves spec_head unchanged.
- Release and wrap: with spec_count=0, free_valid=2'b10, free_pr lane1=7 -> spec_count=1, mem[0]=7.
  - Add 1 more release (PR 9) -> spec_count=2, alloc_pr = {9,7}.
- Flush recovery: from reset, alloc 2 per cycle for 3 cycles; commit_cnt=2 once; then flush -> spec_count=30, alloc_pr = {35,34}.
- Overflow: at reset (spec_count=32), free_valid=2'b01, free_pr=5 -> ovf_err=1, spec_count stays 32.
- Duplicate (FREE_LIST_DUP_CHECK_EN): after one alloc of 32,33, release PR 40 -> dup_err=1, spec_count unchanged. Release PR 32 -> accepted, spec_count+1.

Source files
------------

// File: rtl/free_list_mw_pkg.sv
// Shared sizing constants for the multi-width physical-register free list.
package free_list_mw_pkg;
  localparam int PR_WIDTH    = 6;
  localparam int FL_DEPTH    = 32;
  localparam int ALLOC_WIDTH = 2;
  localparam int FREE_WIDTH  = 2;
  localparam int FL_NUM_ARCH = 32;
endpackage

// File: rtl/free_list_compact.sv
// Combinational prefix-popcount compactor: packs valid lanes into consecutive
// write slots in ascending lane order and reports how many were packed.
module free_list_compact #(
  parameter int PR_W   = 6,
  parameter int FREE_W = 2,
  parameter int CNT_W  = $clog2(FREE_W + 1)
) (
  input  logic [FREE_W-1:0]      valid,
  input  logic [FREE_W*PR_W-1:0] pr,
  output logic [FREE_W*PR_W-1:0] packed_pr,
  output logic [CNT_W-1:0]       cnt
);

  // Walk lanes in order; each valid lane lands in the next free slot.
  always_comb begin
    packed_pr = '0;
    cnt       = '0;
    for (int i = 0; i < FREE_W; i++) begin
      if (valid[i]) begin
        packed_pr[int'(cnt)*PR_W +: PR_W] = pr[i*PR_W +: PR_W];
        cnt = cnt + CNT_W'(1);
      end else begin
        cnt = cnt;
      end
    end
  end

endmodule

// File: rtl/free_list_mw_chk.sv
// Simulation checker: commits may never retire past the speculative head.
module free_list_mw_chk #(
  parameter int PTR_W = 6,
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             rst,
  input logic [PTR_W-1:0] spec_head,
  input logic [PTR_W-1:0] commit_head,
  input logic [CNT_W-1:0] commit_cnt
);

  logic [PTR_W-1:0] inflight;
  assign inflight = spec_head - commit_head;

  a_commit_within_spec: assert property (@(posedge clk) disable iff (!rst)
    PTR_W'(commit_cnt) <= inflight);

endmodule

// File: rtl/free_list_mw.sv
// Multi-width free list with speculative/committed heads for one-cycle flush.
// Optional duplicate-release detection is enabled with FREE_LIST_DUP_CHECK_EN.
module free_list_mw
  import free_list_mw_pkg::*;
#(
  parameter int PR_W     = PR_WIDTH,
  parameter int DEPTH    = FL_DEPTH,
  parameter int ALLOC_W  = ALLOC_WIDTH,
  parameter int FREE_W   = FREE_WIDTH,
  parameter int NUM_ARCH = FL_NUM_ARCH,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int PTR_W   = $clog2(DEPTH) + 1,
  localparam int CNT_W   = $clog2(ALLOC_W + 1),
  localparam int FCNT_W  = $clog2(FREE_W + 1),
  localparam int EXT_W   = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        alloc_cnt,
  output logic                    alloc_ready,
  output logic [ALLOC_W*PR_W-1:0] alloc_pr,
  input  logic [FREE_W-1:0]       free_valid,
  input  logic [FREE_W*PR_W-1:0]  free_pr,
  input  logic [CNT_W-1:0]        commit_cnt,
  input  logic                    flush,
  output logic [PTR_W-1:0]        spec_count,
  output logic                    empty,
  output logic                    ovf_err,
  output logic                    dup_err
);

  logic [PR_W-1:0]          mem_r [DEPTH];
  logic [PTR_W-1:0]         spec_head_r;
  logic [PTR_W-1:0]         commit_head_r;
  logic [PTR_W-1:0]         tail_r;
  logic                     ovf_err_r;
  logic [FREE_W-1:0]        rel_valid_s;
  logic [FREE_W*PR_W-1:0]   wr_pr_s;
  logic [FCNT_W-1:0]        wr_cnt_s;
  logic                     alloc_fire_s;
  logic [CNT_W-1:0]         alloc_amt_s;
  logic                     ovf_s;
  logic [PTR_W-1:0]         commit_next_s;

  function automatic logic [IDX_W-1:0] idx(input logic [PTR_W-1:0] p);
    return p[IDX_W-1:0];
  endfunction

  assign spec_count    = tail_r - spec_head_r;
  assign empty         = (spec_count == '0);
  assign alloc_ready   = (spec_count >= PTR_W'(ALLOC_W));
  assign ovf_err       = ovf_err_r;
  assign commit_next_s = commit_head_r + PTR_W'(commit_cnt);
  assign alloc_fire_s  = alloc_ready && !flush && (alloc_cnt != '0) &&
                         (alloc_cnt <= CNT_W'(ALLOC_W));
  assign alloc_amt_s   = alloc_fire_s ? alloc_cnt : '0;
  // Overflow compares without subtraction so nothing underflows.
  assign ovf_s = ({1'b0, spec_count} + EXT_W'(wr_cnt_s)) >
                 (EXT_W'(DEPTH) + EXT_W'(alloc_amt_s));

  // Allocation lanes read straight out of storage at the speculative head.
  always_comb begin
    alloc_pr = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_pr[i*PR_W +: PR_W] = mem_r[idx(spec_head_r + PTR_W'(i))];
    end
  end

  free_list_compact #(
    .PR_W  (PR_W),
    .FREE_W(FREE_W),
    .CNT_W (FCNT_W)
  ) u_compact (
    .valid    (rel_valid_s),
    .pr       (free_pr),
    .packed_pr(wr_pr_s),
    .cnt      (wr_cnt_s)
  );

`ifdef FREE_LIST_DUP_CHECK_EN
  localparam int NPR = 2 ** PR_W;
  logic [NPR-1:0]    in_list_r;
  logic [NPR-1:0]    in_list_next_s;
  logic [FREE_W-1:0] dup_lane_s;
  logic              dup_err_r;
  logic [PTR_W-1:0]  restore_len_s;

  assign restore_len_s = spec_head_r - commit_next_s;

  // A lane is a duplicate if its PR is already free or an earlier lane frees it too.
  always_comb begin
    dup_lane_s = '0;
    for (int j = 0; j < FREE_W; j++) begin
      if (free_valid[j]) begin
        dup_lane_s[j] = in_list_r[free_pr[j*PR_W +: PR_W]];
        for (int k = 0; k < j; k++) begin
          if (free_valid[k] && (free_pr[k*PR_W +: PR_W] == free_pr[j*PR_W +: PR_W])) begin
            dup_lane_s[j] = 1'b1;
          end else begin
            dup_lane_s[j] = dup_lane_s[j];
          end
        end
      end else begin
        dup_lane_s[j] = 1'b0;
      end
    end
    rel_valid_s = free_valid & ~dup_lane_s;
  end

  // Membership update: allocs clear, flush restores the squashed span, releases set.
  always_comb begin
    in_list_next_s = in_list_r;
    for (int i = 0; i < ALLOC_W; i++) begin
      if (CNT_W'(i) < alloc_amt_s) begin
        in_list_next_s[alloc_pr[i*PR_W +: PR_W]] = 1'b0;
      end else begin
        in_list_next_s = in_list_next_s;
      end
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (PTR_W'(k) < restore_len_s) begin
          in_list_next_s[mem_r[idx(commit_next_s + PTR_W'(k))]] = 1'b1;
        end else begin
          in_list_next_s = in_list_next_s;
        end
      end
    end else begin
      in_list_next_s = in_list_next_s;
    end
    for (int j = 0; j < FREE_W; j++) begin
      if (!ovf_s && rel_valid_s[j]) begin
        in_list_next_s[free_pr[j*PR_W +: PR_W]] = 1'b1;
      end else begin
        in_list_next_s = in_list_next_s;
      end
    end
  end

  // Membership vector and sticky duplicate flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPR; i++) begin
        in_list_r[i] <= (i >= NUM_ARCH) && (i < NUM_ARCH + DEPTH);
      end
      dup_err_r <= 1'b0;
    end else begin
      in_list_r <= in_list_next_s;
      dup_err_r <= dup_err_r | (|dup_lane_s);
    end
  end

  assign dup_err = dup_err_r;
`else
  assign rel_valid_s = free_valid;
  assign dup_err     = 1'b0;
`endif

  // Head/tail pointers and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_head_r   <= '0;
      commit_head_r <= '0;
      tail_r        <= PTR_W'(DEPTH);
      ovf_err_r     <= 1'b0;
    end else begin
      commit_head_r <= commit_next_s;
      if (flush) begin
        spec_head_r <= commit_next_s;
      end else begin
        spec_head_r <= spec_head_r + PTR_W'(alloc_amt_s);
      end
      if (!ovf_s) begin
        tail_r <= tail_r + PTR_W'(wr_cnt_s);
      end else begin
        tail_r <= tail_r;
      end
      ovf_err_r <= ovf_err_r | ovf_s;
    end
  end

  // Storage: preloaded with the non-architectural PRs, written at the tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= PR_W'(NUM_ARCH + i);
      end
    end else begin
      for (int j = 0; j < FREE_W; j++) begin
        if (!ovf_s && (FCNT_W'(j) < wr_cnt_s)) begin
          mem_r[idx(tail_r + PTR_W'(j))] <= wr_pr_s[j*PR_W +: PR_W];
        end else begin
          mem_r[idx(tail_r + PTR_W'(j))] <= mem_r[idx(tail_r + PTR_W'(j))];
        end
      end
    end
  end

  free_list_mw_chk #(
    .PTR_W(PTR_W),
    .CNT_W(CNT_W)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .spec_head  (spec_head_r),
    .commit_head(commit_head_r),
    .commit_cnt (commit_cnt)
  );

endmodule
